// File: rtl/win_fetch.sv
// -----------------------------------------------------------------------------
// win_fetch
// Read side of the line-buffer banks. Waits until KH consecutive banks
// (round-robin, aligned to the writer's bank pointer) hold full rows, sweeps
// them column by column and emits KH-pixel vertical columns over valid/ready.
// Each bank is released with a one-cycle mem_used pulse once it is no longer
// needed. At the end of a frame the whole window is released at once.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   cfg_width     last column index (row = cfg_width+1 pixels)
//   cfg_height    last row index (frame = cfg_height+1 rows)
//   mb_full       per-bank "holds a complete row" level
//   mem_data      per-bank read data, valid one cycle after mb_rd_addr
//   mb_rd_addr    per-bank read address
//   mem_used      one-cycle release pulse per bank
//   col_data      KH pixels, oldest (top) row in bits [PB-1:0]
//   col_x, col_y  column index and window top-row index of col_data
//   col_last      col_x == cfg_width
//   col_valid     col_data valid; col_ready consumer accepts
//   frame_done    one-cycle pulse with the end-of-frame release
// -----------------------------------------------------------------------------
module win_fetch #(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int NM = 4,
  parameter int KH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XB-1:0]    cfg_width,
  input  logic [YB-1:0]    cfg_height,
  input  logic [NM-1:0]    mb_full,
  input  logic [PB-1:0]    mem_data   [NM],
  output logic [XB-1:0]    mb_rd_addr [NM],
  output logic [NM-1:0]    mem_used,
  output logic [KH*PB-1:0] col_data,
  output logic [XB-1:0]    col_x,
  output logic [YB-1:0]    col_y,
  output logic             col_last,
  output logic             col_valid,
  input  logic             col_ready,
  output logic             frame_done
);

  localparam int BB = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [2:0] {S_WAIT, S_SWEEP, S_DRAIN, S_REL, S_RELFRM} state_e;

  typedef struct packed {
    logic [KH*PB-1:0] data;
    logic [XB-1:0]    x;
    logic [YB-1:0]    y;
  } col_t;

  // Bank holding window row k when the window starts at bank 'base'.
  function automatic logic [BB-1:0] bank_of(input logic [BB-1:0] base, input int k);
    return BB'((int'(base) + k) % NM);
  endfunction

  state_e        state_q, state_d;
  logic [BB-1:0] base_q, base_d;
  logic [YB-1:0] row_q, row_d;
  logic [XB-1:0] rcol_q, rcol_d;
  logic [NM-1:0] rdy_q;

  logic          inflight_q;      // a read was issued last cycle
  logic [XB-1:0] rd_x_q;
  logic [YB-1:0] rd_y_q;

  col_t          fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q;

  logic [NM-1:0]    win_mask;
  logic             win_ready;
  logic [KH*PB-1:0] rd_data;
  logic             push, pop, issue;
  logic [1:0]       occ;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    win_mask = '0;
    rd_data  = '0;
    for (int k = 0; k < KH; k++) begin
      win_mask[bank_of(base_q, k)] = 1'b1;
      rd_data[k*PB +: PB]          = mem_data[bank_of(base_q, k)];
    end
  end

  assign win_ready = &(rdy_q | ~win_mask);

  assign col_valid = (cnt_q != 2'd0);
  assign pop       = col_valid & col_ready;
  assign push      = inflight_q;
  // A slot being accepted this cycle counts as free, which keeps one column
  // per cycle flowing with col_ready held high.
  assign occ       = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
  assign issue     = (state_q == S_SWEEP) && (occ < 2'd2);

  assign col_data  = fifo_q[rd_ptr_q].data;
  assign col_x     = fifo_q[rd_ptr_q].x;
  assign col_y     = fifo_q[rd_ptr_q].y;
  assign col_last  = (fifo_q[rd_ptr_q].x == cfg_width);

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      mb_rd_addr[i] = (state_q == S_SWEEP && win_mask[i]) ? rcol_q : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    row_d      = row_q;
    rcol_d     = rcol_q;
    mem_used   = '0;
    frame_done = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        rcol_d = '0;
        if (win_ready) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (issue) begin
          rcol_d = rcol_q + 1'b1;
          if (rcol_q == cfg_width) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && cnt_q == 2'd0) begin
          state_d = (row_q == cfg_height - YB'(KH-1)) ? S_RELFRM : S_REL;
        end
      end
      S_REL: begin
        mem_used[bank_of(base_q, 0)] = 1'b1;
        base_d  = bank_of(base_q, 1);
        row_d   = row_q + 1'b1;
        state_d = S_WAIT;
      end
      S_RELFRM: begin
        // base keeps running across frames to stay aligned with the writer.
        mem_used   = win_mask;
        base_d     = bank_of(base_q, KH);
        row_d      = '0;
        frame_done = 1'b1;
        state_d    = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT;
      base_q     <= '0;
      row_q      <= '0;
      rcol_q     <= '0;
      rdy_q      <= '0;
      inflight_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      row_q      <= row_d;
      rcol_q     <= rcol_d;
      // Release wins over a simultaneous full indication.
      rdy_q      <= (rdy_q | mb_full) & ~mem_used;
      inflight_q <= issue;
      if (issue) begin
        rd_x_q <= rcol_q;
        rd_y_q <= row_q;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: FIFO storage is not reset; cnt_q gates col_valid, so stale entries
  // are never observed and the array maps to plain registers without reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{data: rd_data, x: rd_x_q, y: rd_y_q};
  end

  a_full_vs_release: assert property (@(posedge clk) disable iff (rst)
    (mb_full & mem_used) == '0);

  a_min_height: assert property (@(posedge clk) disable iff (rst)
    cfg_height >= YB'(KH-1));

endmodule
